// File: rtl/mem_responder.sv
// Memory-bus responder: flop-based storage, fixed-latency read pipeline,
// collision strobe and saturating access counters.
module mem_responder #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8,
    parameter int RD_LATENCY = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rd_valid_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  wr_count_o,
    output logic [CNT_W-1:0]  rd_count_o,
    output logic [CNT_W-1:0]  err_count_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]     mem_q  [DEPTH];
    logic [DATA_W-1:0]     mem_d  [DEPTH];
    logic [RD_LATENCY-1:0] pv_q, pv_d;
    logic [DATA_W-1:0]     pd_q   [RD_LATENCY];
    logic [DATA_W-1:0]     pd_d   [RD_LATENCY];
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      wc_q, wc_d, rc_q, rc_d, ec_q, ec_d;

    logic rd_go, collide;

    assign rd_go   = rd_en_i & ~wr_en_i;
    assign collide = rd_en_i & wr_en_i;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] c,
        input logic             en
    );
        return (en && !(&c)) ? c + CNT_W'(1) : c;
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (wr_en_i) mem_d[addr_i] = wdata_i;
    end

    // Data stages only load on a valid beat, so the last stage holds
    // the most recent read result while rd_valid is low.
    always_comb begin
        pv_d    = '0;
        pd_d    = pd_q;
        pv_d[0] = rd_go;
        if (rd_go) pd_d[0] = mem_q[addr_i];
        for (int i = 1; i < RD_LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            if (pv_q[i-1]) pd_d[i] = pd_q[i-1];
        end
    end

    always_comb begin
        err_d = collide;
        wc_d  = sat_inc(wc_q, wr_en_i);
        rc_d  = sat_inc(rc_q, rd_go);
        ec_d  = sat_inc(ec_q, collide);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
            for (int i = 0; i < RD_LATENCY; i++) pd_q[i] <= '0;
            pv_q  <= '0;
            err_q <= 1'b0;
            wc_q  <= '0;
            rc_q  <= '0;
            ec_q  <= '0;
        end else begin
            mem_q <= mem_d;
            pd_q  <= pd_d;
            pv_q  <= pv_d;
            err_q <= err_d;
            wc_q  <= wc_d;
            rc_q  <= rc_d;
            ec_q  <= ec_d;
        end
    end

    assign rdata_o     = pd_q[RD_LATENCY-1];
    assign rd_valid_o  = pv_q[RD_LATENCY-1];
    assign err_o       = err_q;
    assign wr_count_o  = wc_q;
    assign rd_count_o  = rc_q;
    assign err_count_o = ec_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (latency 1 / latency 3 with
// 4-bit counters) share one stimulus stream and a scoreboard model.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] addr = '0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wdata = '0;

    logic [7:0]  rd_a, rd_b;
    logic        rv_a, rv_b, er_a, er_b;
    logic [15:0] wc_a, rc_a, ec_a;
    logic [3:0]  wc_b, rc_b, ec_b;

    always #5 clk = ~clk;

    mem_responder u_dut_a (
        .clk_i(clk), .rst_i(rst), .addr_i(addr),
        .wr_en_i(wr_en), .rd_en_i(rd_en), .wdata_i(wdata),
        .rdata_o(rd_a), .rd_valid_o(rv_a), .err_o(er_a),
        .wr_count_o(wc_a), .rd_count_o(rc_a), .err_count_o(ec_a)
    );

    mem_responder #(
        .RD_LATENCY(3), .RESET_VAL(8'hC3), .CNT_W(4)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .addr_i(addr),
        .wr_en_i(wr_en), .rd_en_i(rd_en), .wdata_i(wdata),
        .rdata_o(rd_b), .rd_valid_o(rv_b), .err_o(er_b),
        .wr_count_o(wc_b), .rd_count_o(rc_b), .err_count_o(ec_b)
    );

    typedef struct {
        logic [7:0] d;
        int         due;
    } rd_t;

    rd_t        qa[$];
    rd_t        qb[$];
    logic [7:0] ma [4];
    logic [7:0] mb [4];
    logic [7:0] last_a, last_b;
    logic       exp_err;
    int         mwc_a, mrc_a, mec_a, mwc_b, mrc_b, mec_b;
    int         ncyc = 0;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, ncyc, got, exp);
        end
    endtask

    task automatic model_clear();
        qa.delete();
        qb.delete();
        for (int i = 0; i < 4; i++) begin
            ma[i] = 8'h00;
            mb[i] = 8'hC3;
        end
        last_a  = 8'h00;
        last_b  = 8'h00;
        exp_err = 1'b0;
        mwc_a = 0; mrc_a = 0; mec_a = 0;
        mwc_b = 0; mrc_b = 0; mec_b = 0;
    endtask

    // Drive one command, let the DUTs sample it, update the model.
    task automatic step(input logic we, input logic re,
                        input logic [1:0] a, input logic [7:0] wd);
        rd_t e;
        wr_en = we;
        rd_en = re;
        addr  = a;
        wdata = wd;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (re && !we) begin
                e.d = ma[a]; e.due = ncyc + 1; qa.push_back(e);
                e.d = mb[a]; e.due = ncyc + 3; qb.push_back(e);
                if (mrc_a < 65535) mrc_a++;
                if (mrc_b < 15) mrc_b++;
            end
            if (we) begin
                ma[a] = wd;
                mb[a] = wd;
                if (mwc_a < 65535) mwc_a++;
                if (mwc_b < 15) mwc_b++;
            end
            if (we && re) begin
                if (mec_a < 65535) mec_a++;
                if (mec_b < 15) mec_b++;
            end
            exp_err = we && re;
        end
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    // Monitor: sample outputs on the falling edge, mid-cycle.
    initial begin
        rd_t e;
        logic ev;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst) begin
                ev = (qa.size() > 0) && (qa[0].due == ncyc);
                if (ev) begin e = qa.pop_front(); last_a = e.d; end
                chk("a_valid", rv_a, ev);
                chk("a_rdata", rd_a, last_a);
                chk("a_err", er_a, exp_err);
                chk("a_wcnt", wc_a, mwc_a);
                chk("a_rcnt", rc_a, mrc_a);
                chk("a_ecnt", ec_a, mec_a);
                ev = (qb.size() > 0) && (qb[0].due == ncyc);
                if (ev) begin e = qb.pop_front(); last_b = e.d; end
                chk("b_valid", rv_b, ev);
                chk("b_rdata", rd_b, last_b);
                chk("b_err", er_b, exp_err);
                chk("b_wcnt", wc_b, mwc_b);
                chk("b_rcnt", rc_b, mrc_b);
                chk("b_ecnt", ec_b, mec_b);
            end
        end
    end

    initial begin
        model_clear();
        do_reset();
        // reset contents
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i), 8'h00);
        idle(4);
        // fill, then back-to-back reads in reverse
        step(1'b1, 1'b0, 2'd0, 8'hA5);
        step(1'b1, 1'b0, 2'd1, 8'h3C);
        step(1'b1, 1'b0, 2'd2, 8'hFF);
        step(1'b1, 1'b0, 2'd3, 8'h01);
        for (int i = 3; i >= 0; i--) step(1'b0, 1'b1, 2'(i), 8'h00);
        idle(4);
        // write-then-read, in-flight overwrite keeps snapshot
        step(1'b1, 1'b0, 2'd2, 8'h11);
        step(1'b0, 1'b1, 2'd2, 8'h00);
        step(1'b1, 1'b0, 2'd2, 8'h22);
        idle(3);
        step(1'b0, 1'b1, 2'd2, 8'h00);
        idle(4);
        // collision
        step(1'b1, 1'b1, 2'd1, 8'h5A);
        idle(1);
        step(1'b0, 1'b1, 2'd1, 8'h00);
        idle(4);
        // reset with reads in flight
        step(1'b0, 1'b1, 2'd0, 8'h00);
        step(1'b0, 1'b1, 2'd1, 8'h00);
        step(1'b0, 1'b1, 2'd2, 8'h00);
        #2;
        do_reset();
        idle(4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i), 8'h00);
        idle(4);
        // counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 2'(i), 8'(i * 7));
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 2'(i), 8'(i + 9));
        for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 2'(i), 8'h00);
        step(1'b0, 1'b1, 2'd3, 8'h00);
        step(1'b1, 1'b0, 2'd3, 8'h77);
        step(1'b0, 1'b1, 2'd3, 8'h00);
        idle(6);
        chk("a_drain", qa.size(), 0);
        chk("b_drain", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
